// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
// Optional build macro used by the top: PIPE_HAZARD_PERF_CNT_EN (performance counters).
package pipe_hazard_pkg;

    // Multi-cycle EX tracking states.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // Load-enable and bubble control for one pipeline stage register.
    typedef struct packed {
        logic en;
        logic bubble;
    } stage_ctrl_t;

    // Canonical RISC-V NOP (addi x0, x0, 0) loaded by a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Build a stage control value from its two fields.
    function automatic stage_ctrl_t stage_ctrl(input logic en, input logic bubble);
        stage_ctrl_t ctrl;
        ctrl.en     = en;
        ctrl.bubble = bubble;
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones,
// clears on the asynchronous active-low reset.
module pipe_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Counter register: increment on inc unless already saturated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != {W{1'b1}})) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall / bubble / flush / redirect controller for the 5-stage core.
// Priority: data-memory wait > multi-cycle EX > redirect > load-use > advance.
// Optional build macro: PIPE_HAZARD_PERF_CNT_EN builds saturating performance
// counters; without it the perf_* ports are tied to zero.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int RF_ADDRESS = 5,
    parameter int PC_W       = 9,
    parameter int MC_LAT_W   = 4,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [RF_ADDRESS-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic                  ex_mc_start,
    input  logic [MC_LAT_W-1:0]   ex_mc_lat,
    input  logic                  ex_redirect,
    input  logic [PC_W-1:0]       ex_target,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  pc_redirect,
    output logic [PC_W-1:0]       pc_next_tgt,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_bubble,
    output logic                  idex_bubble,
    output logic                  exmem_bubble,
    output logic                  memwb_bubble,
    output logic                  busy_state,
    output logic [PERF_W-1:0]     perf_stall,
    output logic [PERF_W-1:0]     perf_flush,
    output logic [PERF_W-1:0]     perf_mc
);

    localparam logic [MC_LAT_W-1:0]   MC_ZERO = {MC_LAT_W{1'b0}};
    localparam logic [MC_LAT_W-1:0]   MC_ONE  = MC_LAT_W'(1);
    localparam logic [RF_ADDRESS-1:0] REG_X0  = {RF_ADDRESS{1'b0}};

    mc_state_e             state_r;
    mc_state_e             state_nxt_s;
    logic [MC_LAT_W-1:0]   mc_cnt_r;
    logic [MC_LAT_W-1:0]   mc_cnt_nxt_s;

    logic                  mem_stall_s;
    logic                  load_use_s;
    logic                  mc_hold_s;
    logic                  pc_en_s;
    logic                  pc_redirect_s;
    stage_ctrl_t           ifid_s;
    stage_ctrl_t           idex_s;
    stage_ctrl_t           exmem_s;
    stage_ctrl_t           memwb_s;

    // Hazard terms: memory wait, load-use dependency, and whether EX is held by a multi-cycle op.
    always_comb begin
        mem_stall_s = mem_req & ~mem_ready;
        load_use_s  = ex_memread & ex_regwrite & (ex_rd != REG_X0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        // In MC_BUSY the count-of-one cycle is the release cycle, so EX is only held above one.
        if (state_r == MC_BUSY) begin
            mc_hold_s = (mc_cnt_r > MC_ONE);
        end else begin
            mc_hold_s = ex_mc_start & (ex_mc_lat != MC_ZERO);
        end
    end

    // Prioritised action selection plus FSM/counter next-state.
    always_comb begin
        state_nxt_s   = state_r;
        mc_cnt_nxt_s  = mc_cnt_r;
        pc_en_s       = 1'b1;
        pc_redirect_s = 1'b0;
        ifid_s        = stage_ctrl(1'b1, 1'b0);
        idex_s        = stage_ctrl(1'b1, 1'b0);
        exmem_s       = stage_ctrl(1'b1, 1'b0);
        memwb_s       = stage_ctrl(1'b1, 1'b0);

        if (mem_stall_s) begin
            // Whole front of the pipe freezes; MEM result is not yet valid so WB gets a bubble.
            pc_en_s       = 1'b0;
            ifid_s.en     = 1'b0;
            idex_s.en     = 1'b0;
            exmem_s.en    = 1'b0;
            memwb_s.bubble = 1'b1;
        end else if (mc_hold_s) begin
            // EX occupied: hold everything upstream, send a bubble down into MEM.
            pc_en_s        = 1'b0;
            ifid_s.en      = 1'b0;
            idex_s.en      = 1'b0;
            exmem_s.bubble = 1'b1;
            state_nxt_s    = MC_BUSY;
            if (state_r == RUN) begin
                mc_cnt_nxt_s = ex_mc_lat;
            end else begin
                mc_cnt_nxt_s = mc_cnt_r - MC_ONE;
            end
        end else begin
            // Normal cycle (or MC release cycle, which returns the FSM to RUN).
            state_nxt_s = RUN;
            if (state_r == MC_BUSY) begin
                mc_cnt_nxt_s = MC_ZERO;
            end else begin
                mc_cnt_nxt_s = mc_cnt_r;
            end

            if (ex_redirect) begin
                // ID/IF hold wrong-path instructions, which also makes any load-use moot.
                pc_redirect_s  = 1'b1;
                ifid_s.bubble  = 1'b1;
                idex_s.bubble  = 1'b1;
            end else if (load_use_s) begin
                pc_en_s        = 1'b0;
                ifid_s.en      = 1'b0;
                idex_s.bubble  = 1'b1;
            end else begin
                pc_en_s        = 1'b1;
            end
        end
    end

    // FSM state and multi-cycle counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= RUN;
            mc_cnt_r <= MC_ZERO;
        end else begin
            state_r  <= state_nxt_s;
            mc_cnt_r <= mc_cnt_nxt_s;
        end
    end

    // Output drive: reset forces every stage to load a bubble with no enables.
    always_comb begin
        if (!reset) begin
            pc_en        = 1'b0;
            pc_redirect  = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            ifid_bubble  = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            memwb_bubble = 1'b1;
            busy_state   = 1'b0;
        end else begin
            pc_en        = pc_en_s;
            pc_redirect  = pc_redirect_s;
            ifid_en      = ifid_s.en;
            idex_en      = idex_s.en;
            exmem_en     = exmem_s.en;
            memwb_en     = memwb_s.en;
            ifid_bubble  = ifid_s.bubble;
            idex_bubble  = idex_s.bubble;
            exmem_bubble = exmem_s.bubble;
            memwb_bubble = memwb_s.bubble;
            busy_state   = (state_r == MC_BUSY);
        end
    end

    assign pc_next_tgt = ex_target;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    pipe_perf_cnt #(.W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_en),
        .count (perf_stall)
    );

    pipe_perf_cnt #(.W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_redirect),
        .count (perf_flush)
    );

    pipe_perf_cnt #(.W(PERF_W)) u_perf_mc (
        .clk   (clk),
        .reset (reset),
        .inc   (busy_state),
        .count (perf_mc)
    );
`else
    assign perf_stall = {PERF_W{1'b0}};
    assign perf_flush = {PERF_W{1'b0}};
    assign perf_mc    = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (PERF_W overridden to 4).
module tb_pipe_hazard_ctrl;

    localparam int PERF_W = 4;
    localparam int PMAX   = 15;

    // Control vector: pc_en, pc_redirect, ifid/idex/exmem/memwb en, same four bubbles, busy_state
    localparam logic [10:0] C_RST   = 11'b0_0_0000_1111_0;
    localparam logic [10:0] C_RUN   = 11'b1_0_1111_0000_0;
    localparam logic [10:0] C_LU    = 11'b0_0_0111_0100_0;
    localparam logic [10:0] C_RD    = 11'b1_1_1111_1100_0;
    localparam logic [10:0] C_MCS   = 11'b0_0_0011_0010_0;
    localparam logic [10:0] C_MCB   = 11'b0_0_0011_0010_1;
    localparam logic [10:0] C_REL   = 11'b1_0_1111_0000_1;
    localparam logic [10:0] C_RELRD = 11'b1_1_1111_1100_1;
    localparam logic [10:0] C_MST_R = 11'b0_0_0001_0001_0;
    localparam logic [10:0] C_MST_B = 11'b0_0_0001_0001_1;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_memread, ex_regwrite, ex_mc_start;
    logic [3:0]  ex_mc_lat;
    logic        ex_redirect;
    logic [8:0]  ex_target;
    logic        mem_req, mem_ready;
    logic        pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, busy_state;
    logic [8:0]  pc_next_tgt;
    logic [PERF_W-1:0] perf_stall, perf_flush, perf_mc;
    logic [10:0] ctl;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_stall    = 0;
    int exp_flush    = 0;
    int exp_mc       = 0;

    pipe_hazard_ctrl #(.PERF_W(PERF_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_lat    (ex_mc_lat),
        .ex_redirect  (ex_redirect),
        .ex_target    (ex_target),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .pc_redirect  (pc_redirect),
        .pc_next_tgt  (pc_next_tgt),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_bubble  (ifid_bubble),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .memwb_bubble (memwb_bubble),
        .busy_state   (busy_state),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_mc      (perf_mc)
    );

    assign ctl = {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_bubble, idex_bubble, exmem_bubble, memwb_bubble, busy_state};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < PMAX) ? v + 1 : v;
    endfunction

    task automatic clr_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        ex_mc_start = 1'b0; ex_mc_lat = 4'd0;
        ex_redirect = 1'b0; ex_target = 9'd0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] r);
        ex_rd = r; ex_memread = 1'b1; ex_regwrite = 1'b1;
        id_rs1 = r; id_use_rs1 = 1'b1;
    endtask

    // Check the control vector for the current inputs, then advance one clock
    // and update the performance-counter model from the expected vector.
    task automatic cycle(input string tag, input logic [10:0] exp);
        #1;
        check_eq(tag, {21'd0, ctl}, {21'd0, exp});
        @(posedge clk);
        if (!exp[10]) exp_stall = sat_inc(exp_stall);
        if (exp[9])   exp_flush = sat_inc(exp_flush);
        if (exp[0])   exp_mc    = sat_inc(exp_mc);
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPE_HAZARD_PERF_CNT_EN
        check_eq({tag, "_stall"}, {28'd0, perf_stall}, exp_stall);
        check_eq({tag, "_flush"}, {28'd0, perf_flush}, exp_flush);
        check_eq({tag, "_mc"},    {28'd0, perf_mc},    exp_mc);
`else
        check_eq({tag, "_stall"}, {28'd0, perf_stall}, 32'd0);
        check_eq({tag, "_flush"}, {28'd0, perf_flush}, 32'd0);
        check_eq({tag, "_mc"},    {28'd0, perf_mc},    32'd0);
`endif
    endtask

    initial begin
        clr_inputs();
        reset = 1'b0;
        #2;
        check_eq("reset_ctl", {21'd0, ctl}, {21'd0, C_RST});
        check_perf("reset_perf");
        @(posedge clk); #1;
        reset = 1'b1;

        // Idle flow and target passthrough
        ex_target = 9'h1A5;
        cycle("idle", C_RUN);
        check_eq("tgt_pass", {23'd0, pc_next_tgt}, 32'h1A5);

        // Load-use variants
        clr_inputs(); set_load_use(5'd5);
        cycle("lu_rs1", C_LU);
        clr_inputs();
        cycle("lu_after", C_RUN);
        ex_rd = 5'd7; ex_memread = 1'b1; ex_regwrite = 1'b1;
        id_rs1 = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cycle("lu_rs2", C_LU);
        clr_inputs(); set_load_use(5'd0);
        cycle("lu_x0", C_RUN);
        clr_inputs(); set_load_use(5'd5); ex_regwrite = 1'b0;
        cycle("lu_noregwr", C_RUN);
        clr_inputs(); set_load_use(5'd5); id_use_rs1 = 1'b0; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
        cycle("lu_nomatch", C_RUN);

        // Redirect overrides simultaneous load-use
        clr_inputs(); set_load_use(5'd5); ex_redirect = 1'b1; ex_target = 9'h040;
        cycle("redirect", C_RD);
        check_eq("redirect_tgt", {23'd0, pc_next_tgt}, 32'h040);
        clr_inputs();
        cycle("redirect_after", C_RUN);

        // Multi-cycle op, latency 3: start stays high to show it is ignored while busy
        ex_mc_start = 1'b1; ex_mc_lat = 4'd3;
        cycle("mc3_start", C_MCS);
        cycle("mc3_busy1", C_MCB);
        cycle("mc3_busy2", C_MCB);
        cycle("mc3_release", C_REL);
        clr_inputs();
        cycle("mc3_after", C_RUN);

        // Zero latency is a single-cycle op
        ex_mc_start = 1'b1; ex_mc_lat = 4'd0;
        cycle("mc0", C_RUN);
        clr_inputs();
        cycle("mc0_after", C_RUN);

        // Memory wait during MC_BUSY with count 2 freezes the countdown
        ex_mc_start = 1'b1; ex_mc_lat = 4'd3;
        cycle("mcm_start", C_MCS);
        cycle("mcm_busy3", C_MCB);
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle("mcm_stall1", C_MST_B);
        cycle("mcm_stall2", C_MST_B);
        mem_ready = 1'b1;
        cycle("mcm_busy2", C_MCB);
        cycle("mcm_release", C_REL);
        clr_inputs();
        cycle("mcm_after", C_RUN);

        // Memory wait defers redirect and load-use
        set_load_use(5'd9); ex_redirect = 1'b1; ex_target = 9'h040;
        mem_req = 1'b1; mem_ready = 1'b0;
        cycle("mst_run", C_MST_R);
        mem_ready = 1'b1;
        cycle("mst_then_rd", C_RD);
        clr_inputs();
        cycle("mst_after", C_RUN);

        // Asynchronous reset in MC_BUSY with count 5
        ex_mc_start = 1'b1; ex_mc_lat = 4'd6;
        cycle("rst_mc_start", C_MCS);
        cycle("rst_mc_busy6", C_MCB);
        reset = 1'b0;
        exp_stall = 0; exp_flush = 0; exp_mc = 0;
        #1;
        check_eq("async_reset", {21'd0, ctl}, {21'd0, C_RST});
        check_perf("async_perf");
        @(posedge clk); #1;
        reset = 1'b1;
        clr_inputs();
        cycle("post_reset", C_RUN);

        // Latency 1 with a redirect on the release cycle
        ex_mc_start = 1'b1; ex_mc_lat = 4'd1;
        cycle("mc1_start", C_MCS);
        ex_redirect = 1'b1; ex_target = 9'h040;
        cycle("mc1_rel_rd", C_RELRD);
        clr_inputs();
        cycle("mc1_after", C_RUN);

        // Maximum latency 15: 16 EX cycles in total
        ex_mc_start = 1'b1; ex_mc_lat = 4'd15;
        cycle("mc15_start", C_MCS);
        for (int i = 0; i < 14; i++) begin
            cycle("mc15_busy", C_MCB);
        end
        cycle("mc15_release", C_REL);
        clr_inputs();
        cycle("mc15_after", C_RUN);

        check_perf("final_perf");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
